// File: rtl/uart_receiver.sv
// UART receiver, 8N1, LSB first. Mid-bit sampling through a two-flop synchroniser.
// Each received byte is held until the consumer acknowledges it with read.
// Framing errors pulse for one cycle. Overrun errors stay set until read.
module uart_receiver #(
  parameter int CLKS_PER_BIT = 40,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 Receiver,
  input  logic                 read,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_ready,
  output logic                 busy,
  output logic                 framing_error,
  output logic                 overrun_error
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  // Handshake: data_ready acts as valid and read acts as ready. data_out is stable while
  // data_ready=1. An edge with read=1 consumes the byte and clears data_ready and overrun_error.
  // If a byte completes on that same edge, the new byte replaces the old one and data_ready stays 1.

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

  state_t               state, state_n;
  logic [1:0]           sync;
  logic                 rx_s;
  logic [CNT_W-1:0]     cnt, cnt_n;
  logic [IDX_W-1:0]     idx, idx_n;
  logic [DATA_BITS-1:0] shift, shift_n;
  logic [DATA_BITS-1:0] data_out_n;
  logic                 data_ready_n, framing_error_n, overrun_error_n;

  assign rx_s = sync[1];
  assign busy = (state != IDLE);

  // Two-flop synchroniser on the asynchronous line. It idles high so reset cannot fake a start bit.
  always_ff @(posedge clk) begin
    if (reset) sync <= 2'b11;
    else       sync <= {sync[0], Receiver};
  end

  // State register and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      idx           <= '0;
      shift         <= '0;
      data_out      <= '0;
      data_ready    <= 1'b0;
      framing_error <= 1'b0;
      overrun_error <= 1'b0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      idx           <= idx_n;
      shift         <= shift_n;
      data_out      <= data_out_n;
      data_ready    <= data_ready_n;
      framing_error <= framing_error_n;
      overrun_error <= overrun_error_n;
    end
  end

  // Next-state and output logic. cnt_n defaults to 0, so every state change or bit boundary clears it.
  always_comb begin
    state_n         = state;
    cnt_n           = '0;
    idx_n           = idx;
    shift_n         = shift;
    data_out_n      = data_out;
    data_ready_n    = data_ready;
    framing_error_n = 1'b0;
    overrun_error_n = overrun_error;

    if (read) begin
      data_ready_n    = 1'b0;
      overrun_error_n = 1'b0;
    end

    case (state)
      IDLE: begin
        if (!rx_s) state_n = START;
      end
      START: begin
        if (cnt == CNT_MID) begin
          // Confirm the start bit at its midpoint. A short glitch falls back to IDLE silently.
          if (!rx_s) begin
            state_n = DATA;
            idx_n   = '0;
          end else begin
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt == CNT_LAST) begin
          shift_n[idx] = rx_s;
          if (idx == IDX_LAST) state_n = STOP;
          else                 idx_n   = idx + IDX_W'(1);
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      STOP: begin
        if (cnt == CNT_LAST) begin
          if (rx_s) begin
            state_n = IDLE;
            if (!data_ready || read) begin
              data_out_n   = shift;
              data_ready_n = 1'b1;
            end else begin
              overrun_error_n = 1'b1;
            end
          end else begin
            // A low stop bit may be a break condition. Wait for the line to go high before rearming.
            framing_error_n = 1'b1;
            state_n         = BRK;
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      BRK: begin
        if (rx_s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver. A timeline model predicts every output on every cycle.
// Each frame's completion edge and busy window come from the frame start edge and the latency rule.
// The main sequence also checks some hand-computed literal values at chosen cycles.
module tb_uart_receiver;

  localparam int CPB   = 40;
  localparam int DB    = 8;
  localparam int N_LAT = 2 + CPB / 2 + (DB + 1) * CPB;  // 382
  localparam int MAXC  = 16384;

  // clock / reset / DUT
  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          Receiver = 1'b1;
  logic          read = 1'b0;
  logic [DB-1:0] data_out;
  logic          data_ready, busy, framing_error, overrun_error;

  always #5 clk = ~clk;

  uart_receiver #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
    .clk(clk), .reset(reset), .Receiver(Receiver), .read(read),
    .data_out(data_out), .data_ready(data_ready), .busy(busy),
    .framing_error(framing_error), .overrun_error(overrun_error)
  );

  // scoreboard state
  typedef struct { int cyc; logic [DB-1:0] data; logic good; } ev_t;
  ev_t           ev_q[$];
  logic [DB-1:0] exp_q[$];
  bit            busy_map [MAXC];
  int            cyc = 0;
  int            total = 0;
  int            bad = 0;
  logic [DB-1:0] m_out = '0;
  logic          m_ready = 1'b0, m_ovr = 1'b0, m_fe = 1'b0, m_load = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Model: counts edges and applies the read and frame-completion rules at each edge.
  initial begin
    ev_t  ev;
    logic old_ready, rd;
    forever begin
      @(posedge clk);
      cyc++;
      m_fe   = 1'b0;
      m_load = 1'b0;
      if (reset) begin
        m_out   = '0;
        m_ready = 1'b0;
        m_ovr   = 1'b0;
        ev_q.delete();
        for (int i = cyc; i < MAXC; i++) busy_map[i] = 1'b0;
      end else begin
        rd        = read;
        old_ready = m_ready;
        if (rd) begin
          m_ready = 1'b0;
          m_ovr   = 1'b0;
        end
        if (ev_q.size() > 0 && ev_q[0].cyc == cyc) begin
          ev = ev_q.pop_front();
          if (ev.good) begin
            if (!old_ready || rd) begin
              m_out   = ev.data;
              m_ready = 1'b1;
              m_load  = 1'b1;
            end else begin
              m_ovr = 1'b1;
            end
          end else begin
            m_fe = 1'b1;
          end
        end
      end
    end
  end

  // Compare process: runs on every cycle, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (cyc >= 1) begin
        chk("data_out", data_out, m_out);
        chk("data_ready", data_ready, m_ready);
        chk("busy", busy, busy_map[cyc]);
        chk("framing_error", framing_error, m_fe);
        chk("overrun_error", overrun_error, m_ovr);
        if (m_load) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL byte_order at cycle %0d: got %0h expected no byte", cyc, data_out);
          end else begin
            chk("byte_order", data_out, exp_q.pop_front());
          end
        end
      end
    end
  end

  // driver tasks (start and end just after a rising edge)
  task automatic wait_neg(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_read();
    read = 1'b1;
    @(posedge clk);
    #1 read = 1'b0;
  endtask

  task automatic read_at(input int target);
    wait_neg(target - 1);
    read = 1'b1;
    @(posedge clk);
    #1 read = 1'b0;
  endtask

  // abort_at > 0: after that many bit-cycles, drop the frame and hold reset for 3 edges
  task automatic send_frame(input logic [DB-1:0] d, input logic stop, input int abort_at);
    int         e, last;
    logic [9:0] fr;
    e  = cyc + 1;
    fr = {stop, d, 1'b0};
    ev_q.push_back('{e + N_LAT, d, stop});
    last = stop ? e + N_LAT - 1 : e + 10 * CPB + 1;
    for (int i = e + 2; i <= last && i < MAXC; i++) busy_map[i] = 1'b1;
    for (int b = 0; b < 10; b++) begin
      Receiver = fr[b];
      for (int c = 0; c < CPB; c++) begin
        if (abort_at > 0 && b * CPB + c == abort_at) begin
          Receiver = 1'b1;
          reset    = 1'b1;
          repeat (3) @(posedge clk);
          #1 reset = 1'b0;
          return;
        end
        @(posedge clk);
        #1;
      end
    end
    Receiver = 1'b1;
  endtask

  task automatic glitch(input int len);
    int e;
    e = cyc + 1;
    for (int i = e + 2; i <= e + CPB / 2 + 1; i++) busy_map[i] = 1'b1;
    Receiver = 1'b0;
    repeat (len) @(posedge clk);
    #1 Receiver = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: cycle %0d reached without finishing", cyc);
    $fatal(1, "watchdog expired");
  end

  // stimulus
  initial begin
    int t;
    wait_neg(1);
    chk("reset_data_out", data_out, 8'h00);
    chk("reset_data_ready", data_ready, 1'b0);
    chk("reset_busy", busy, 1'b0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    idle(10);

    // 1: 0x18, exact latency
    exp_q.push_back(8'h18);
    t = cyc + 1;
    fork
      send_frame(8'h18, 1'b1, 0);
      begin
        wait_neg(t + 381);
        chk("t1_ready_early", data_ready, 1'b0);
        wait_neg(t + 382);
        chk("t1_ready", data_ready, 1'b1);
        chk("t1_data", data_out, 8'h18);
      end
    join
    idle(5);
    chk("t1_busy_after", busy, 1'b0);
    pulse_read();
    idle(5);

    // 2: 0x55 then 0xAA back-to-back, read after each
    exp_q.push_back(8'h55);
    exp_q.push_back(8'hAA);
    t = cyc + 1;
    fork
      begin
        send_frame(8'h55, 1'b1, 0);
        send_frame(8'hAA, 1'b1, 0);
      end
      begin
        read_at(t + 390);
        wait_neg(t + 400 + 382);
        chk("t2_second", data_out, 8'hAA);
        read_at(t + 400 + 390);
      end
    join
    idle(10);

    // 3: 15-cycle glitch
    glitch(15);
    idle(40);
    chk("t3_ready", data_ready, 1'b0);
    chk("t3_busy", busy, 1'b0);

    // 4: framing error on 0xFF, then 0x0F
    exp_q.push_back(8'h0F);
    t = cyc + 1;
    fork
      send_frame(8'hFF, 1'b0, 0);
      begin
        wait_neg(t + 382);
        chk("t4_fe_pulse", framing_error, 1'b1);
        wait_neg(t + 383);
        chk("t4_fe_clear", framing_error, 1'b0);
      end
    join
    idle(20);
    send_frame(8'h0F, 1'b1, 0);
    idle(5);
    chk("t4_data", data_out, 8'h0F);
    pulse_read();
    idle(5);

    // 5: overrun with 0x51 then 0x96, no read
    exp_q.push_back(8'h51);
    send_frame(8'h51, 1'b1, 0);
    send_frame(8'h96, 1'b1, 0);
    idle(5);
    chk("t5_data", data_out, 8'h51);
    chk("t5_overrun", overrun_error, 1'b1);
    pulse_read();
    idle(2);
    chk("t5_ready_clr", data_ready, 1'b0);
    chk("t5_overrun_clr", overrun_error, 1'b0);
    chk("t5_data_kept", data_out, 8'h51);

    // 6: reset mid-data, then a clean 0x88
    send_frame(8'h88, 1'b1, 150);
    idle(10);
    chk("t6_no_byte", data_ready, 1'b0);
    exp_q.push_back(8'h88);
    send_frame(8'h88, 1'b1, 0);
    idle(5);
    chk("t6_data", data_out, 8'h88);
    pulse_read();
    idle(5);

    // 7: read coinciding with completion
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1, 0);
    idle(5);
    exp_q.push_back(8'hC3);
    t = cyc + 1;
    fork
      send_frame(8'hC3, 1'b1, 0);
      read_at(t + N_LAT);
    join
    idle(3);
    chk("t7_data", data_out, 8'hC3);
    chk("t7_ready", data_ready, 1'b1);
    chk("t7_overrun", overrun_error, 1'b0);
    pulse_read();
    idle(3);
    pulse_read();
    idle(3);
    chk("t7_read_when_empty", data_ready, 1'b0);
    chk("exp_q_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
